// File: rtl/acc_pkg.sv
// Shared definitions for the multi-bank accumulator: operation codes and a
// helper for sizing the bank-select field.
package acc_pkg;

  typedef enum logic [3:0] {
    OP_NOP    = 4'd0,
    OP_LOAD   = 4'd1,
    OP_ADD    = 4'd2,
    OP_ADC    = 4'd3,
    OP_SUB    = 4'd4,
    OP_AND    = 4'd5,
    OP_OR     = 4'd6,
    OP_XOR    = 4'd7,
    OP_SHL    = 4'd8,
    OP_SHR    = 4'd9,
    OP_PUSH   = 4'd10,
    OP_POP    = 4'd11,
    OP_CLR    = 4'd12,
    OP_CLRALL = 4'd13,
    OP_RSV14  = 4'd14,
    OP_RSV15  = 4'd15
  } op_t;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/acc_stack.sv
// LIFO used to save and restore {carry, value} bank contexts. Overflow and
// underflow are reported as single-cycle pulses; the caller keeps them sticky.
module acc_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           clear,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               din,
  output logic [WIDTH-1:0]               top,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty,
  output logic                           overflow,
  output logic                           underflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    top_ptr;
  logic             do_push;
  logic             do_pop;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign overflow  = push && full;
  assign underflow = pop && empty;
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign top_ptr   = count_q - CW'(1);
  assign top       = mem[top_ptr[AW-1:0]];
  assign count     = count_q;

  always_ff @(posedge Clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    if (Reset || clear) begin
      count_q <= '0;
    end else if (do_push) begin
      count_q <= count_q + CW'(1);
    end else if (do_pop) begin
      count_q <= count_q - CW'(1);
    end
  end

  // NOTE: the storage array has no reset; only the pointer defines validity,
  // which lets the array map onto plain RAM or ungated flops.
  always_ff @(posedge Clk) begin
    if (!Reset && do_push) begin
      mem[count_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/acc_bank.sv
// N independent W-bit accumulators with per-bank carry, a shared context stack
// and a sticky stack-error flag. One operation on bank Sel per clock.
module acc_bank
  import acc_pkg::*;
#(
  parameter int W = 8,
  parameter int N = 4,
  parameter int S = 4
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic [3:0]                   Op,
  input  logic [sel_width(N)-1:0]      Sel,
  input  logic [W-1:0]                 DataIn,
  output logic [W-1:0]                 DataOut,
  output logic                         CarryOut,
  output logic                         Zero,
  output logic [$clog2(S+1)-1:0]       StackCount,
  output logic                         StackFull,
  output logic                         StackEmpty,
  output logic                         Error
);

  localparam int SW = sel_width(N);
  localparam logic [SW:0] NUM_BANKS = (SW + 1)'(N);

  typedef struct packed {
    logic         carry;
    logic [W-1:0] val;
  } entry_t;

  logic [W-1:0] acc_q [N];
  logic [N-1:0] carry_q;
  logic         error_q;

  op_t          op;
  logic         sel_ok;
  logic [W-1:0] cur_val;
  logic         cur_carry;
  logic [W-1:0] nxt_val;
  logic         nxt_carry;
  logic         wr_en;
  logic         push;
  logic         pop;
  logic         clr_all;
  entry_t       push_entry;
  entry_t       top_entry;
  logic         overflow;
  logic         underflow;

  assign op        = op_t'(Op);
  assign sel_ok    = ({1'b0, Sel} < NUM_BANKS);
  assign cur_val   = sel_ok ? acc_q[Sel] : '0;
  assign cur_carry = sel_ok ? carry_q[Sel] : 1'b0;

  assign push_entry = '{carry: cur_carry, val: cur_val};

  acc_stack #(
    .DEPTH(S),
    .WIDTH(W + 1)
  ) u_stack (
    .Clk       (Clk),
    .Reset     (Reset),
    .clear     (clr_all),
    .push      (push),
    .pop       (pop),
    .din       (push_entry),
    .top       (top_entry),
    .count     (StackCount),
    .full      (StackFull),
    .empty     (StackEmpty),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    nxt_val   = cur_val;
    nxt_carry = cur_carry;
    wr_en     = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    clr_all   = 1'b0;
    if (sel_ok) begin
      case (op)
        OP_LOAD: begin
          nxt_val   = DataIn;
          nxt_carry = 1'b0;
          wr_en     = 1'b1;
        end
        OP_ADD: begin
          {nxt_carry, nxt_val} = {1'b0, cur_val} + {1'b0, DataIn};
          wr_en = 1'b1;
        end
        OP_ADC: begin
          {nxt_carry, nxt_val} = {1'b0, cur_val} + {1'b0, DataIn}
                               + {{W{1'b0}}, cur_carry};
          wr_en = 1'b1;
        end
        // Bit W of the (W+1)-bit difference is the borrow.
        OP_SUB: begin
          {nxt_carry, nxt_val} = {1'b0, cur_val} - {1'b0, DataIn};
          wr_en = 1'b1;
        end
        OP_AND: begin
          nxt_val = cur_val & DataIn;
          wr_en   = 1'b1;
        end
        OP_OR: begin
          nxt_val = cur_val | DataIn;
          wr_en   = 1'b1;
        end
        OP_XOR: begin
          nxt_val = cur_val ^ DataIn;
          wr_en   = 1'b1;
        end
        OP_SHL: begin
          nxt_carry = cur_val[W-1];
          nxt_val   = {cur_val[W-2:0], 1'b0};
          wr_en     = 1'b1;
        end
        OP_SHR: begin
          nxt_carry = cur_val[0];
          nxt_val   = {1'b0, cur_val[W-1:1]};
          wr_en     = 1'b1;
        end
        OP_PUSH: push = 1'b1;
        OP_POP: begin
          pop = 1'b1;
          if (!StackEmpty) begin
            nxt_carry = top_entry.carry;
            nxt_val   = top_entry.val;
            wr_en     = 1'b1;
          end
        end
        OP_CLR: begin
          nxt_val   = '0;
          nxt_carry = 1'b0;
          wr_en     = 1'b1;
        end
        OP_CLRALL: clr_all = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset || clr_all) begin
      for (int i = 0; i < N; i++) begin
        acc_q[i] <= '0;
      end
      carry_q <= '0;
    end else if (wr_en) begin
      acc_q[Sel]   <= nxt_val;
      carry_q[Sel] <= nxt_carry;
    end
  end

  // Error stays set until an explicit clear.
  always_ff @(posedge Clk) begin
    if (Reset || clr_all) begin
      error_q <= 1'b0;
    end else if (overflow || underflow) begin
      error_q <= 1'b1;
    end
  end

  assign DataOut  = cur_val;
  assign CarryOut = cur_carry;
  assign Zero     = (cur_val == '0);
  assign Error    = error_q;

endmodule

// File: tb/tb_acc_bank.sv
// Self-checking bench for acc_bank: directed scenarios followed by random ops,
// all compared against an arithmetic reference model with a queue-based stack.
module tb_acc_bank;
  import acc_pkg::*;

  localparam int W   = 8;
  localparam int N   = 4;
  localparam int S   = 4;
  localparam int MOD = 1 << W;

  logic         Clk = 1'b0;
  logic         Reset;
  logic [3:0]   Op;
  logic [1:0]   Sel;
  logic [W-1:0] DataIn;
  logic [W-1:0] DataOut;
  logic         CarryOut;
  logic         Zero;
  logic [2:0]   StackCount;
  logic         StackFull;
  logic         StackEmpty;
  logic         Error;

  // Second instance with a non-power-of-two bank count for the invalid-Sel case.
  logic [3:0]   op3;
  logic [1:0]   sel3;
  logic [W-1:0] din3;
  logic [W-1:0] dout3;
  logic         cout3;
  logic         zero3;
  logic [1:0]   cnt3;
  logic         full3;
  logic         empty3;
  logic         err3;

  int checks = 0;
  int errors = 0;

  int m_acc [N];
  int m_c   [N];
  int m_stk [$];
  int m_err;

  always #5 Clk = ~Clk;

  acc_bank #(.W(W), .N(N), .S(S)) dut (
    .Clk(Clk), .Reset(Reset), .Op(Op), .Sel(Sel), .DataIn(DataIn),
    .DataOut(DataOut), .CarryOut(CarryOut), .Zero(Zero),
    .StackCount(StackCount), .StackFull(StackFull), .StackEmpty(StackEmpty),
    .Error(Error)
  );

  acc_bank #(.W(W), .N(3), .S(2)) dut3 (
    .Clk(Clk), .Reset(Reset), .Op(op3), .Sel(sel3), .DataIn(din3),
    .DataOut(dout3), .CarryOut(cout3), .Zero(zero3),
    .StackCount(cnt3), .StackFull(full3), .StackEmpty(empty3),
    .Error(err3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_acc[i] = 0;
      m_c[i]   = 0;
    end
    m_stk.delete();
    m_err = 0;
  endtask

  task automatic check_sel(input int sel, input string tag);
    Sel = sel[1:0];
    #1;
    check({tag, ".data"},  32'(DataOut),    32'(m_acc[sel]));
    check({tag, ".carry"}, 32'(CarryOut),   32'(m_c[sel]));
    check({tag, ".zero"},  32'(Zero),       32'(m_acc[sel] == 0));
    check({tag, ".count"}, 32'(StackCount), 32'(m_stk.size()));
    check({tag, ".full"},  32'(StackFull),  32'(m_stk.size() == S));
    check({tag, ".empty"}, 32'(StackEmpty), 32'(m_stk.size() == 0));
    check({tag, ".error"}, 32'(Error),      32'(m_err));
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < N; i++) begin
      check_sel(i, tag);
    end
  endtask

  task automatic do_op(input logic [3:0] op, input int sel, input int din, input string tag);
    int a, c, t, e;
    @(negedge Clk);
    Op     = op;
    Sel    = sel[1:0];
    DataIn = din[W-1:0];
    @(posedge Clk);
    a = m_acc[sel];
    c = m_c[sel];
    case (op)
      OP_LOAD: begin a = din; c = 0; end
      OP_ADD:  begin t = a + din;     a = t % MOD; c = t / MOD; end
      OP_ADC:  begin t = a + din + c; a = t % MOD; c = t / MOD; end
      OP_SUB:  begin c = (din > a) ? 1 : 0; a = (a - din + MOD) % MOD; end
      OP_AND:  a = a & din;
      OP_OR:   a = a | din;
      OP_XOR:  a = a ^ din;
      OP_SHL:  begin c = a / (MOD / 2); a = (a * 2) % MOD; end
      OP_SHR:  begin c = a % 2; a = a / 2; end
      OP_PUSH: begin
        if (m_stk.size() == S) m_err = 1;
        else m_stk.push_back(c * MOD + a);
      end
      OP_POP: begin
        if (m_stk.size() == 0) m_err = 1;
        else begin
          e = m_stk.pop_back();
          a = e % MOD;
          c = e / MOD;
        end
      end
      OP_CLR: begin a = 0; c = 0; end
      default: ;
    endcase
    m_acc[sel] = a;
    m_c[sel]   = c;
    if (op == OP_CLRALL) model_reset();
    #1;
    Op = OP_NOP;
    check_sel(sel, tag);
  endtask

  initial begin
    Reset = 1'b1;
    Op = OP_NOP; Sel = '0; DataIn = '0;
    op3 = OP_NOP; sel3 = '0; din3 = '0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    check_all("reset");

    // Basic add with carry out, then carry consumed by ADC.
    do_op(OP_LOAD, 0, 'hF0, "ld_f0");
    do_op(OP_ADD,  0, 'h20, "add_20");
    check("add_20.const", 32'(DataOut), 32'h10);
    check("add_20.cconst", 32'(CarryOut), 32'h1);
    do_op(OP_ADC,  0, 'h00, "adc_00");
    check("adc_00.const", 32'(DataOut), 32'h11);

    // 16-bit add 0x12FF + 0x0001 across banks 0 and 1.
    do_op(OP_LOAD, 1, 'h12, "ld_hi");
    do_op(OP_LOAD, 0, 'hFF, "ld_lo");
    do_op(OP_ADD,  0, 'h01, "add_lo");
    check("add_lo.carry_const", 32'(CarryOut), 32'h1);
    // Propagate bank 0's carry: copy it into bank 1 by SHL/ADC-free means is not
    // possible, so the high half uses ADC with operand 1 equal to carry.
    do_op(OP_ADC,  1, 32'(CarryOut), "adc_hi");
    check("adc_hi.const", 32'(DataOut), 32'h13);
    check_sel(0, "lo_after");
    check("lo_after.const", 32'(DataOut), 32'h00);

    // Borrow and zero flag.
    do_op(OP_LOAD, 0, 'h03, "ld_03");
    do_op(OP_SUB,  0, 'h05, "sub_05");
    check("sub_05.const", 32'(DataOut), 32'hFE);
    do_op(OP_LOAD, 0, 'h00, "ld_00");

    // Shifts.
    do_op(OP_LOAD, 2, 'h81, "ld_81");
    do_op(OP_SHL,  2, 0,    "shl");
    check("shl.const", 32'(DataOut), 32'h02);
    do_op(OP_LOAD, 2, 'h01, "ld_01");
    do_op(OP_SHR,  2, 0,    "shr");
    check("shr.zero_const", 32'(Zero), 32'h1);

    // Stack overflow, LIFO pop order, underflow, CLRALL.
    for (int i = 0; i <= S; i++) begin
      do_op(OP_LOAD, 2, 'h30 + i, "stk_ld");
      do_op(OP_PUSH, 2, 0, "stk_push");
      if (i == S - 1) check("stk_full_const", 32'(StackFull), 32'h1);
    end
    check("ovf_err_const", 32'(Error), 32'h1);
    check("ovf_cnt_const", 32'(StackCount), 32'(S));
    for (int i = 0; i < S; i++) begin
      do_op(OP_POP, 3, 0, "stk_pop");
      check("stk_pop.lifo", 32'(DataOut), 32'('h30 + S - 1 - i));
    end
    do_op(OP_POP, 3, 0, "stk_unf");
    check("stk_unf.bank_const", 32'(DataOut), 32'h30);
    do_op(OP_CLRALL, 1, 0, "clrall");
    check_all("clrall_all");

    // Reset wins over a coincident LOAD.
    do_op(OP_LOAD, 1, 'h55, "pre_rst");
    do_op(OP_PUSH, 1, 0,    "pre_rst_push");
    @(negedge Clk);
    Reset = 1'b1; Op = OP_LOAD; Sel = 2'd0; DataIn = 8'hAA;
    @(posedge Clk);
    model_reset();
    #1;
    Reset = 1'b0; Op = OP_NOP;
    check_all("rst_ld");

    // Invalid Sel on a three-bank instance changes nothing.
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      op3 = OP_LOAD; sel3 = 2'(i); din3 = 8'(8'hC0 + i);
    end
    @(negedge Clk);
    op3 = OP_ADD; sel3 = 2'd3; din3 = 8'h11;
    @(negedge Clk);
    op3 = OP_PUSH; sel3 = 2'd3;
    @(negedge Clk);
    op3 = OP_NOP;
    for (int i = 0; i < 3; i++) begin
      sel3 = 2'(i);
      #1;
      check("badsel.bank", 32'(dout3), 32'(8'hC0 + i));
    end
    check("badsel.count", 32'(cnt3), 32'h0);
    check("badsel.err", 32'(err3), 32'h0);

    // Random operations against the model.
    for (int k = 0; k < 400; k++) begin
      do_op(4'($urandom_range(0, 15)), $urandom_range(0, N - 1),
            $urandom_range(0, MOD - 1), "rand");
    end
    check_all("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
